// File: rtl/aes_pkg.sv
// Shared AES block types and row helpers used by the block FIFO and its bench.
package aes_pkg;

  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;
  localparam int AES_BLK_W  = 128;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  // Row n of a block; row 0 sits in the LSBs.
  function automatic aes_word_t aes_row(input aes_block_t blk, input int unsigned n);
    return blk[n*32 +: 32];
  endfunction

endpackage

// File: rtl/aes_fifo_ptr.sv
// Wrap-around pointer register with increment enable and synchronous clear.
module aes_fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/aes_block_fifo.sv
// Circular buffer of AES state blocks with show-ahead read and occupancy flags.
// Define AES_FIFO_ERR_EN to add sticky overflow/underflow outputs (ovf, udf).
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int WORD_W   = AES_WORD_W,
  parameter int WORDS    = AES_WORDS,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int BLK_W   = WORD_W * WORDS,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wen,
  input  logic [BLK_W-1:0] wdata,
  output logic             full,
  output logic             almost_full,
  input  logic             ren,
  output logic [BLK_W-1:0] rdata,
  output logic             empty,
`ifdef AES_FIFO_ERR_EN
  output logic             ovf,
  output logic             udf,
`endif
  output logic [CNT_W-1:0] count
);

  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  // Flags come from the pre-edge count, so a full buffer rejects a push even when a pop lands.
  assign push = wen && !full  && !clr;
  assign pop  = ren && !empty && !clr;

  aes_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  aes_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (clr)              count_d = '0;
    else if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wdata;
  end

  assign rdata       = mem_q[rd_ptr];
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

`ifdef AES_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wen && full);
    udf_d = udf_q | (ren && empty);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_aes_block_fifo.sv
// Randomised and directed bench for aes_block_fifo against a queue-based model.
module tb_aes_block_fifo;
  import aes_pkg::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         wen = 1'b0;
  logic         ren = 1'b0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata;
  logic         full, almost_full, empty;
  logic [3:0]   count;
`ifdef AES_FIFO_ERR_EN
  logic         ovf, udf;
  logic         m_ovf = 1'b0, m_udf = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] q[$];

  always #5 clk = ~clk;

  aes_block_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wen         (wen),
    .wdata       (wdata),
    .full        (full),
    .almost_full (almost_full),
    .ren         (ren),
    .rdata       (rdata),
    .empty       (empty),
`ifdef AES_FIFO_ERR_EN
    .ovf         (ovf),
    .udf         (udf),
`endif
    .count       (count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/count"}, 128'(count), 128'(q.size()));
    chk({tag, "/empty"}, 128'(empty), 128'(q.size() == 0));
    chk({tag, "/full"}, 128'(full), 128'(q.size() == DEPTH));
    chk({tag, "/afull"}, 128'(almost_full), 128'(q.size() >= DEPTH - 2));
    if (q.size() != 0) chk({tag, "/rdata"}, rdata, q[0]);
`ifdef AES_FIFO_ERR_EN
    chk({tag, "/ovf"}, 128'(ovf), 128'(m_ovf));
    chk({tag, "/udf"}, 128'(udf), 128'(m_udf));
`endif
  endtask

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock with the given request; the model is updated from pre-edge occupancy.
  task automatic step(input string tag, input logic w, input logic r, input logic c,
                      input logic [127:0] d);
    bit do_push, do_pop;
    wen = w; ren = r; clr = c; wdata = d;
    do_push = w && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
`ifdef AES_FIFO_ERR_EN
    if (w && q.size() == DEPTH) m_ovf = 1'b1;
    if (r && q.size() == 0)     m_udf = 1'b1;
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
`endif
    @(posedge clk); #1;
    if (c) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #12;
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step("idle_ren", 1'b0, 1'b1, 1'b0, '0);

    step("push_known", 1'b1, 1'b0, 1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    step("idle", 1'b0, 1'b0, 1'b0, '0);
    chk("row0", 128'(aes_row(rdata, 0)), 128'h CCDDEEFF);
    chk("row3", 128'(aes_row(rdata, 3)), 128'h 00112233);
    step("pop_known", 1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) step("fill8", 1'b1, 1'b0, 1'b0, rnd_blk());
    step("push9", 1'b1, 1'b0, 1'b0, rnd_blk());
    for (int i = 0; i < DEPTH; i++) step("drain8", 1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 1'b0, rnd_blk());
    for (int i = 0; i < 5; i++) step("pop5", 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step("wrap6", 1'b1, 1'b0, 1'b0, rnd_blk());
    for (int i = 0; i < 6; i++) step("wrapread", 1'b0, 1'b1, 1'b0, '0);

    for (int i = 0; i < 3; i++) step("fill3", 1'b1, 1'b0, 1'b0, rnd_blk());
    for (int i = 0; i < 10; i++) step("rw_at3", 1'b1, 1'b1, 1'b0, rnd_blk());
    for (int i = 0; i < 5; i++) step("to_full", 1'b1, 1'b0, 1'b0, rnd_blk());
    step("rw_full", 1'b1, 1'b1, 1'b0, rnd_blk());
    for (int i = 0; i < 7; i++) step("to_empty", 1'b0, 1'b1, 1'b0, '0);
    step("rw_empty", 1'b1, 1'b1, 1'b0, rnd_blk());

    for (int i = 0; i < 3; i++) step("fill4", 1'b1, 1'b0, 1'b0, rnd_blk());
    step("clr_wen", 1'b1, 1'b0, 1'b1, rnd_blk());

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, rnd_blk());
    wen = 1'b1; wdata = rnd_blk();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    q.delete();
`ifdef AES_FIFO_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
    check_state("async_rst");
    wen = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2000; i++) begin
      int pw, pr;
      pw = (i < 1000) ? 70 : 35;
      pr = (i < 1000) ? 35 : 70;
      step("rand", $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           $urandom_range(0, 199) == 0, rnd_blk());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
